// File: rtl/move_sequencer_pkg.sv
// move_seq_pkg: shared face encodings, FSM states and queued-move record for move_sequencer.
package move_seq_pkg;
    localparam int NUM_MOTORS = 6;
    typedef enum logic [2:0] {FACE_U, FACE_D, FACE_F, FACE_B, FACE_L, FACE_R} face_e;
    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_LOW, WAIT_DONE, SETTLE} state_e;
    typedef struct packed {
        logic [2:0] face;
        logic       ccw;
        logic       half;
    } move_t;
endpackage

// File: rtl/move_sequencer_if.sv
// move_sequencer_if: valid/ready move offer from the solver into the sequencer queue.
interface move_sequencer_if;
    logic       move_valid;
    logic       move_ready;
    logic [2:0] move_face;
    logic       move_ccw;
    logic       move_half;
    modport master(output move_valid, move_face, move_ccw, move_half, input move_ready);
    modport slave(input move_valid, move_face, move_ccw, move_half, output move_ready);
endinterface

// File: rtl/move_sequencer_fifo.sv
// move_fifo: synchronous queue with register-held head word and full/empty flags.
module move_fifo #(
    parameter int W     = 5,
    parameter int DEPTH = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr;
    logic [AW:0]  rd;
    logic         wr_en;
    assign full  = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
    assign empty = wr == rd;
    assign dout  = mem[rd[AW-1:0]];
    assign wr_en = push && (!full || pop);
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr <= '0;
            rd <= '0;
        end else begin
            if (wr_en) wr <= wr + 1'b1;
            if (pop && !empty) rd <= rd + 1'b1;
        end
    end
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/move_sequencer.sv
// move_sequencer: queues face turns and sequences them onto six stepper drivers.
// Define MOVE_SEQ_COUNT_EN to build the completed-move counter on moves_done.
module move_sequencer
    import move_seq_pkg::*;
#(
    parameter int STEPS_PER_QUARTER = 50,
    parameter int FIFO_DEPTH        = 16,
    parameter int SETTLE_CYCLES     = 1000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    move_sequencer_if.slave       mv,
    output logic [NUM_MOTORS-1:0] drv_start,
    output logic [7:0]            drv_steps,
    output logic [NUM_MOTORS-1:0] drv_dir,
    input  logic [NUM_MOTORS-1:0] drv_done,
    output logic                  busy,
    output logic                  err_face,
    output logic [15:0]           moves_done
);
    localparam logic [7:0]  STEPS_Q     = 8'(STEPS_PER_QUARTER);
    localparam logic [7:0]  STEPS_H     = 8'(2 * STEPS_PER_QUARTER);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES == 0 ? 0 : SETTLE_CYCLES - 1);
    state_e      state;
    move_t       din;
    move_t       head;
    logic        full;
    logic        empty;
    logic        rdy_q;
    logic        xfer;
    logic        legal;
    logic        pop;
    logic [2:0]  face_q;
    logic [15:0] cnt;
    assign din           = '{face: mv.move_face, ccw: mv.move_ccw, half: mv.move_half};
    assign mv.move_ready = rdy_q && !full;
    assign xfer          = mv.move_valid && mv.move_ready;
    assign legal         = mv.move_face <= FACE_R;
    assign pop           = state == LOAD;
    assign busy          = state != IDLE || !empty;
    move_fifo #(.W($bits(move_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock(clock),
        .reset_n(reset_n),
        .push(xfer && legal),
        .pop(pop),
        .din(din),
        .dout(head),
        .full(full),
        .empty(empty)
    );
    // rdy_q holds move_ready low for the first clock after reset release
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdy_q    <= 1'b0;
            err_face <= 1'b0;
        end else begin
            rdy_q    <= 1'b1;
            err_face <= err_face || (xfer && !legal);
        end
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            face_q    <= '0;
            drv_start <= '0;
            drv_steps <= '0;
            drv_dir   <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: if (!empty) state <= LOAD;
                LOAD: begin
                    face_q    <= head.face;
                    drv_steps <= head.half ? STEPS_H : STEPS_Q;
                    drv_dir   <= NUM_MOTORS'(head.ccw) << head.face;
                    drv_start <= NUM_MOTORS'(1) << head.face;
                    state     <= START;
                end
                START: begin
                    drv_start <= '0;
                    state     <= WAIT_LOW;
                end
                WAIT_LOW: if (!drv_done[face_q]) state <= WAIT_DONE;
                WAIT_DONE: if (drv_done[face_q]) begin
                    cnt   <= '0;
                    state <= SETTLE;
                end
                SETTLE: if (cnt == SETTLE_LAST) state <= IDLE; else cnt <= cnt + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
`ifdef MOVE_SEQ_COUNT_EN
    logic done_ev;
    assign done_ev = state == WAIT_DONE && drv_done[face_q];
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) moves_done <= '0;
        else if (done_ev) moves_done <= moves_done + 1'b1;
    end
`else
    assign moves_done = '0;
`endif
endmodule

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer: directed vector table plus multi-cycle corner sequences for move_sequencer.
module tb_move_sequencer;
`ifdef MOVE_SEQ_COUNT_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [5:0]  drv_start;
    logic [7:0]  drv_steps;
    logic [5:0]  drv_dir;
    logic [5:0]  drv_done = 6'h3f;
    logic        busy;
    logic        err_face;
    logic [15:0] moves_done;
    logic        drv_en = 1'b1;
    int          dcnt [6] = '{default: 0};
    int          checks = 0;
    int          fails = 0;
    int          cyc = 0;
    int          starts = 0;
    int          dbl = 0;
    int          last_done_cyc = 0;
    int          last_gap = 0;
    logic        prev_st = 1'b0;
    logic [5:0]  prev_done = 6'h3f;
    logic [5:0]  st_vec = '0;
    logic [7:0]  st_steps = '0;
    logic [5:0]  st_dir = '0;

    move_sequencer_if mv();

    move_sequencer #(.STEPS_PER_QUARTER(50), .FIFO_DEPTH(16), .SETTLE_CYCLES(10)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .mv(mv),
        .drv_start(drv_start),
        .drv_steps(drv_steps),
        .drv_dir(drv_dir),
        .drv_done(drv_done),
        .busy(busy),
        .err_face(err_face),
        .moves_done(moves_done)
    );

    always #5 clock = ~clock;

    // driver model: done drops the cycle after start, rises 60 enabled cycles later
    always @(posedge clock) begin
        for (int i = 0; i < 6; i++) begin
            if (drv_start[i]) begin
                drv_done[i] <= 1'b0;
                dcnt[i] <= 60;
            end else if (drv_en && dcnt[i] > 0) begin
                dcnt[i] <= dcnt[i] - 1;
                if (dcnt[i] == 1) drv_done[i] <= 1'b1;
            end
        end
    end

    always @(negedge clock) begin
        cyc = cyc + 1;
        if (|drv_start) begin
            starts = starts + 1;
            st_vec = drv_start;
            st_steps = drv_steps;
            st_dir = drv_dir;
            last_gap = cyc - last_done_cyc;
            if (prev_st) dbl = dbl + 1;
        end
        prev_st = |drv_start;
        if (|(drv_done & ~prev_done)) last_done_cyc = cyc;
        prev_done = drv_done;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic push(input logic [2:0] f, input logic c, input logic h);
        int k;
        k = 0;
        while (!mv.move_ready && k < 2000) begin
            tick();
            k++;
        end
        if (!mv.move_ready) begin
            chk("push_ready_timeout", 0, 1);
            return;
        end
        mv.move_valid = 1'b1;
        mv.move_face = f;
        mv.move_ccw = c;
        mv.move_half = h;
        @(posedge clock);
        #1;
        mv.move_valid = 1'b0;
    endtask

    task automatic wait_start(input int target, input string nm);
        int k;
        k = 0;
        while (starts < target && k < 500) begin
            tick();
            k++;
        end
        chk(nm, starts, target);
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while (busy && k < 1000) begin
            tick();
            k++;
        end
        chk(nm, busy, 0);
    endtask

    typedef struct {
        logic [2:0] face;
        logic       ccw;
        logic       half;
        logic [5:0] exp_start;
        logic [7:0] exp_steps;
        logic       exp_dir;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int s0;
        mv.move_valid = 1'b0;
        mv.move_face = '0;
        mv.move_ccw = 1'b0;
        mv.move_half = 1'b0;
        vecs[0] = '{3'd2, 1'b0, 1'b0, 6'b000100, 8'd50,  1'b0};
        vecs[1] = '{3'd5, 1'b1, 1'b1, 6'b100000, 8'd100, 1'b1};
        vecs[2] = '{3'd0, 1'b1, 1'b0, 6'b000001, 8'd50,  1'b1};
        vecs[3] = '{3'd3, 1'b0, 1'b1, 6'b001000, 8'd100, 1'b0};
        vecs[4] = '{3'd4, 1'b1, 1'b0, 6'b010000, 8'd50,  1'b1};
        vecs[5] = '{3'd1, 1'b1, 1'b1, 6'b000010, 8'd100, 1'b1};

        #1;
        chk("rst_drv_start", drv_start, 0);
        chk("rst_drv_steps", drv_steps, 0);
        chk("rst_busy", busy, 0);
        chk("rst_move_ready", mv.move_ready, 0);
        repeat (3) tick();
        reset_n = 1'b1;
        chk("ready_low_at_release", mv.move_ready, 0);
        tick();
        chk("ready_one_cycle_after_release", mv.move_ready, 1);

        foreach (vecs[i]) begin
            s0 = starts;
            push(vecs[i].face, vecs[i].ccw, vecs[i].half);
            wait_start(s0 + 1, $sformatf("v%0d_start_seen", i));
            chk($sformatf("v%0d_start_vec", i), st_vec, vecs[i].exp_start);
            chk($sformatf("v%0d_steps", i), st_steps, vecs[i].exp_steps);
            chk($sformatf("v%0d_dir", i), st_dir[vecs[i].face], vecs[i].exp_dir);
            tick();
            chk($sformatf("v%0d_start_one_cycle", i), drv_start, 0);
            wait_idle($sformatf("v%0d_idle", i));
            chk($sformatf("v%0d_steps_held", i), drv_steps, vecs[i].exp_steps);
            chk($sformatf("v%0d_dir_held", i), drv_dir[vecs[i].face], vecs[i].exp_dir);
        end
        chk("no_double_pulse", dbl, 0);
        chk("moves_done_after_table", moves_done, CNT_EN * 6);

        s0 = starts;
        chk("err_clear_before", err_face, 0);
        push(3'd7, 1'b0, 1'b0);
        tick();
        chk("err_face_set", err_face, 1);
        chk("illegal_not_queued", busy, 0);
        repeat (50) tick();
        chk("illegal_no_start", starts, s0);
        chk("err_face_sticky", err_face, 1);

        s0 = starts;
        push(3'd0, 1'b0, 1'b0);
        push(3'd4, 1'b1, 1'b1);
        push(3'd2, 1'b1, 1'b0);
        for (int j = 0; j < 3; j++) begin
            wait_start(s0 + j + 1, $sformatf("b2b_start%0d", j));
            if (j > 0) chk($sformatf("b2b_gap%0d_ge10", j), int'(last_gap >= 10), 1);
        end
        wait_idle("b2b_idle");
        chk("b2b_three_starts", starts - s0, 3);
        chk("moves_done_after_b2b", moves_done, CNT_EN * 9);

        drv_en = 1'b0;
        for (int j = 0; j < 17; j++) push(3'(j % 6), 1'b0, 1'b0);
        tick();
        chk("full_ready_low", mv.move_ready, 0);
        chk("full_busy", busy, 1);
        repeat (5) tick();
        chk("full_ready_stays_low", mv.move_ready, 0);
        drv_en = 1'b1;
        begin
            int k;
            k = 0;
            while (!mv.move_ready && k < 300) begin
                tick();
                k++;
            end
        end
        chk("ready_resumes_on_pop", mv.move_ready, 1);

        s0 = starts;
        wait_start(s0 + 1, "pre_reset_start");
        repeat (5) tick();
        reset_n = 1'b0;
        #1;
        chk("midrst_drv_start", drv_start, 0);
        chk("midrst_drv_steps", drv_steps, 0);
        chk("midrst_drv_dir", drv_dir, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_err_face", err_face, 0);
        chk("midrst_moves_done", moves_done, 0);
        chk("midrst_ready", mv.move_ready, 0);
        repeat (3) tick();
        reset_n = 1'b1;
        s0 = starts;
        repeat (150) tick();
        chk("no_start_after_reset", starts, s0);
        chk("idle_after_reset", busy, 0);
        push(3'd1, 1'b0, 1'b1);
        wait_start(s0 + 1, "post_reset_start");
        chk("post_reset_vec", st_vec, 6'b000010);
        chk("post_reset_steps", st_steps, 100);
        wait_idle("post_reset_idle");
        chk("moves_done_post_reset", moves_done, CNT_EN);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/move_sequencer.md
MOVE_SEQUENCER -- requirements
Module: move_sequencer

Interface
REQ-001 SHALL have parameter STEPS_PER_QUARTER, default 50, giving motor steps per 90-degree face turn (legal 1..127).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, giving the move queue depth (power of two, 2..64).
REQ-003 SHALL have parameter SETTLE_CYCLES, default 1000, giving idle clocks between consecutive moves (legal 0..65535).
REQ-004 SHALL have port clock, input, 1 bit: single system clock; all logic on posedge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port move_valid, input, 1 bit: a move is offered on move_face, move_ccw and move_half.
REQ-007 SHALL have port move_ready, output, 1 bit: queue can accept; transfer occurs when move_valid and move_ready are both high on a clock edge.
REQ-008 SHALL have port move_face, input, 3 bits: face index 0..5 (U,D,F,B,L,R); values 6 and 7 are illegal.
REQ-009 SHALL have port move_ccw, input, 1 bit: direction, 1 = counter-clockwise.
REQ-010 SHALL have port move_half, input, 1 bit: 1 = 180-degree turn.
REQ-011 SHALL have port drv_start, output, 6 bits: one-hot single-cycle start pulse, one bit per stepper_driver.
REQ-012 SHALL have port drv_steps, output, 8 bits: step count shared by all drivers.
REQ-013 SHALL have port drv_dir, output, 6 bits: per-motor direction, held for the whole move.
REQ-014 SHALL have port drv_done, input, 6 bits: per-motor done from the drivers.
REQ-015 SHALL have port busy, output, 1 bit: high when the FSM is not IDLE or the queue is non-empty.
REQ-016 SHALL have port err_face, output, 1 bit: sticky flag, set when an illegal face is offered.
REQ-017 SHALL have port moves_done, output, 16 bits: count of completed moves.

Function
REQ-018 SHALL queue accepted moves in FIFO order; move_ready = !full.
REQ-019 SHALL drop an offered move with face 6/7 (not queued, still handshaken) and set err_face.
REQ-020 SHALL use FSM states IDLE, LOAD, START, WAIT_LOW, WAIT_DONE, SETTLE.
REQ-021 SHALL transition IDLE->LOAD when the queue is non-empty; LOAD pops the head and registers face, dir and steps.
REQ-022 SHALL set steps = STEPS_PER_QUARTER for a quarter turn and 2*STEPS_PER_QUARTER for a half turn, computed at 8 bits with no truncation inside the legal range.
REQ-023 SHALL in START assert drv_start[face] for exactly one cycle, with drv_steps and drv_dir valid on that same cycle, and go to WAIT_LOW.
REQ-024 SHALL stay in WAIT_LOW until drv_done[face]==0, then go to WAIT_DONE; this absorbs the driver's one-cycle registered done deassertion.
REQ-025 SHALL leave WAIT_DONE when drv_done[face]==1, increment moves_done (wrapping 65535->0) and go to SETTLE.
REQ-026 SHALL count SETTLE_CYCLES clocks in SETTLE and then return to IDLE; with SETTLE_CYCLES=0, SETTLE lasts exactly one cycle.
REQ-027 SHALL ignore drv_done bits of non-selected motors.
REQ-028 SHALL allow a push and a pop in the same cycle when the queue is full; the pop frees the slot next cycle, and move_ready reflects the pre-pop state.
REQ-029 SHALL keep drv_steps and drv_dir stable from START until the next LOAD.

Reset
REQ-030 SHALL on reset_n low immediately set: state IDLE, queue empty, drv_start=0, drv_steps=0, drv_dir=0, busy=0, err_face=0, moves_done=0, move_ready=0.
REQ-031 SHALL raise move_ready one cycle after reset_n is deasserted.
REQ-032 SHALL, on reset mid-move, abandon the move without a further start pulse; a driver already running completes on its own.

Configuration
REQ-033 SHALL, with macro MOVE_SEQ_COUNT_EN defined, implement moves_done as specified in REQ-025.
REQ-034 SHALL, without MOVE_SEQ_COUNT_EN, drive moves_done constant 0 and remove the counter logic.

Structure
REQ-035 SHALL place the face encodings, FSM state enum and NUM_MOTORS=6 in package move_seq_pkg.
REQ-036 SHALL implement the queue as sub-module move_fifo (synchronous, first-word registered, full/empty flags).

Verification
REQ-037 SHALL cover: reset, push face=2 ccw=0 half=0 -> drv_start=6'b000100 for one cycle, drv_steps=50, drv_dir[2]=0.
REQ-038 SHALL cover: push face=5 half=1 ccw=1 -> drv_steps=100, drv_dir[5]=1.
REQ-039 SHALL cover: 3 back-to-back moves with SETTLE_CYCLES=10 and a driver model (done low 1 cycle after start, high 60 cycles later) -> 3 start pulses, each >=10 cycles after the prior done; moves_done=3.
REQ-040 SHALL cover: push 17 moves with no drivers completing -> move_ready low after 16 queued (the first already popped to the FSM), resumes on pop.
REQ-041 SHALL cover: push face=7 -> err_face=1, no drv_start, queue unchanged.
REQ-042 SHALL cover: assert reset_n low in WAIT_DONE -> all outputs zero immediately; no start pulse after release until a new push.
